// File: rtl/mem_resp_queue.sv
// mem_resp_queue - MEM stage between EXE and WB.
//
// Holds up to DEPTH in-flight instructions in program order, pairs in-order
// data_sram responses with the oldest entry still waiting for data, and
// performs load lane selection and sign/zero extension on the head entry.
// A flush drops every entry and remembers how many responses are still owed
// to the flushed entries so those late beats are discarded.
//
// Optional feature macro: MS_RDATA_BYPASS_EN
//   defined   : a response routed to a waiting head entry retires it in the
//               same cycle, with the result extracted straight from rdata.
//   undefined : response data is always registered before retirement.
//
// Parameters
//   DATA_W  data bus width, 32 or 64
//   PAY_W   side-band width forwarded untouched to WB
//   DEPTH   queue entries, power of 2, >= 2
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   es2ms_*             instruction offered by EXE (valid, need_mem, exc,
//                       load_op {ld,lhu,lbu,lw,lh,lb}, addr_lo, result, payload)
//   ms_allowin          MEM can take an instruction this cycle
//   data_sram_data_ok   response beat, data_sram_rdata its data
//   ws_allowin          WB accepts the head entry
//   ms2ws_valid/result/payload  completed head entry towards WB
//   ms_flush            flush from WB
//   ms_busy             some valid entry is still waiting for data
module mem_resp_queue #(
  parameter int DATA_W = 32,
  parameter int PAY_W  = 96,
  parameter int DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          es2ms_valid,
  output logic                          ms_allowin,
  input  logic                          es2ms_need_mem,
  input  logic                          es2ms_exc,
  input  logic [5:0]                    es2ms_load_op,
  input  logic [$clog2(DATA_W/8)-1:0]   es2ms_addr_lo,
  input  logic [DATA_W-1:0]             es2ms_result,
  input  logic [PAY_W-1:0]              es2ms_payload,
  input  logic                          data_sram_data_ok,
  input  logic [DATA_W-1:0]             data_sram_rdata,
  input  logic                          ws_allowin,
  output logic                          ms2ws_valid,
  output logic [DATA_W-1:0]             ms2ws_result,
  output logic [PAY_W-1:0]              ms2ws_payload,
  input  logic                          ms_flush,
  output logic                          ms_busy
);

  localparam int AW = $clog2(DATA_W/8);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_CW = (CW+1)'(DEPTH);

  // Lane select and extension of a load from the raw response word.
  function automatic logic [DATA_W-1:0] load_extract(
    input logic [5:0]        op,
    input logic [AW-1:0]     alo,
    input logic [DATA_W-1:0] word
  );
    logic        [7:0]        b;
    logic        [15:0]       h;
    logic        [31:0]       w;
    logic signed [7:0]        bs;
    logic signed [15:0]       hs;
    logic signed [31:0]       wsg;
    logic        [DATA_W-1:0] r;
    b = 8'(word >> {alo, 3'b000});
    h = 16'(word >> {alo[AW-1:1], 4'b0000});
    if (DATA_W == 64) w = 32'(word >> {alo[AW-1], 5'b00000});
    else              w = word[31:0];
    bs  = b;
    hs  = h;
    wsg = w;
    r   = '0;
    if (op[0])                            r = DATA_W'(bs);
    else if (op[3])                       r = DATA_W'(b);
    else if (op[1])                       r = DATA_W'(hs);
    else if (op[4])                       r = DATA_W'(h);
    else if (op[2] || (op[5] && DATA_W == 32)) r = DATA_W'(wsg);
    else if (op[5])                       r = word;
    return r;
  endfunction

  // Entry storage; only the valid bits, pointers and counters are reset.
  logic [DEPTH-1:0]  valid_q, need_q, got_q;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [5:0]        op_q   [DEPTH];
  logic [AW-1:0]     alo_q  [DEPTH];
  logic [DATA_W-1:0] res_q  [DEPTH];
  logic [PAY_W-1:0]  pay_q  [DEPTH];
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q, cancel_q;

  logic [DEPTH-1:0]  wait_vec;
  logic [CW-1:0]     pending;
  logic              wait_found;
  logic [PW-1:0]     wait_idx;
  logic [PW-1:0]     scan_idx;
  logic              beat_drop, beat_route, route_wr;
  logic              head_valid, head_need, head_got, head_done;
  logic              byp_hit;
  logic [DATA_W-1:0] head_word;
  logic              enq, deq;

  assign wait_vec = valid_q & need_q & ~got_q;

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) pending = pending + CW'(wait_vec[i]);
  end

  // Responses come back in request order, so the owner of a beat is the
  // first waiting entry counted from the head.
  always_comb begin
    wait_found = 1'b0;
    wait_idx   = head_q;
    scan_idx   = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PW'(i);
      if (!wait_found && wait_vec[scan_idx]) begin
        wait_found = 1'b1;
        wait_idx   = scan_idx;
      end
    end
  end

  assign beat_drop  = data_sram_data_ok & (cancel_q != '0);
  assign beat_route = data_sram_data_ok & (cancel_q == '0) & wait_found;

  assign head_valid = valid_q[head_q];
  assign head_need  = need_q[head_q];
  assign head_got   = got_q[head_q];
  assign head_done  = ~head_need | head_got;

`ifdef MS_RDATA_BYPASS_EN
  assign byp_hit     = beat_route & head_valid & head_need & ~head_got;
  assign head_word   = byp_hit ? data_sram_rdata : data_q[head_q];
  assign ms2ws_valid = head_valid & (head_done | byp_hit);
`else
  assign byp_hit     = 1'b0;
  assign head_word   = data_q[head_q];
  assign ms2ws_valid = head_valid & head_done;
`endif

  assign ms2ws_result  = !ms2ws_valid          ? '0 :
                         (op_q[head_q] == '0)  ? res_q[head_q] :
                         load_extract(op_q[head_q], alo_q[head_q], head_word);
  assign ms2ws_payload = ms2ws_valid ? pay_q[head_q] : '0;

  // Owed responses (waiting entries plus beats still to be discarded) are
  // capped at DEPTH so the response counters can never overflow.
  assign ms_allowin = ~ms_flush & (count_q < DEPTH_C) &
                      (({1'b0, pending} + {1'b0, cancel_q}) < DEPTH_CW);
  assign ms_busy    = |wait_vec;

  assign enq      = es2ms_valid & ms_allowin;
  assign deq      = ms2ws_valid & ws_allowin & ~ms_flush;
  // A bypassed head that leaves this cycle needs no copy of its data.
  assign route_wr = beat_route & ~(byp_hit & deq);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      cancel_q <= '0;
    end else if (ms_flush) begin
      valid_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      // A beat arriving now is either already owed (cancel_q>0) or belongs
      // to one of the flushed waiting entries; both cases subtract one.
      cancel_q <= cancel_q + pending - CW'(data_sram_data_ok);
    end else begin
      if (beat_drop) cancel_q <= cancel_q - CW'(1);
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      if (deq) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      count_q <= count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      need_q[tail_q] <= es2ms_need_mem & ~es2ms_exc;
      got_q[tail_q]  <= 1'b0;
      op_q[tail_q]   <= es2ms_load_op;
      alo_q[tail_q]  <= es2ms_addr_lo;
      res_q[tail_q]  <= es2ms_result;
      pay_q[tail_q]  <= es2ms_payload;
    end
    if (route_wr) begin
      got_q[wait_idx]  <= 1'b1;
      data_q[wait_idx] <= data_sram_rdata;
    end
  end

  // A beat with nothing owed and nobody waiting is a protocol violation.
  assert property (@(posedge clk) disable iff (reset)
    data_sram_data_ok |-> ((cancel_q != '0) || wait_found));

endmodule
